control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: none; all encodings come from the shared package.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ena  in  1  clock enable; when low, every register holds its value.
REQ-006 run  in  1  free-run mode; when low, fetches need a step pulse.
REQ-007 step  in  1  single-step request; acts on its rising edge.
REQ-008 mem_valid  in  1  fetch data valid; qualifies instr_in.
REQ-009 instr_in  in  8  fetched instruction byte.
REQ-010 ctrl_in  in  16  control word from the control LUT for the current state and instruction.
REQ-011 state  out  3  sequencer state, driven to the control LUT.
REQ-012 instruction  out  8  instruction register, driven to the control LUT and datapath.
REQ-013 mem_req  out  1  fetch request.
REQ-014 halted  out  1  sticky flag for an illegal instruction.
REQ-015 retired  out  8  count of completed instructions; wraps at 256.

Function
REQ-016 State encodings: FETCH=000, DECODE=001, EXECUTE=010, WRITEBACK=011, OUTPUT=100, HALT=111.
REQ-017 Fetch gating:
- mem_req = 1 only when state is FETCH and (run=1 or step_pending=1) and halted=0.
- The rising edge of step sets step_pending in any state.
- step_pending clears when a fetch is accepted.
REQ-018 Fetch accept: in FETCH with mem_req=1 and mem_valid=1, load instruction <= instr_in and go to DECODE on the next edge; otherwise stay in FETCH.
REQ-019 mem_valid is ignored whenever mem_req=0.
REQ-020 DECODE, illegal case: ctrl_in == 16'h0000 and instruction != 8'h00 -> go to HALT and set halted=1.
REQ-021 DECODE, all other cases -> go to EXECUTE.
REQ-022 EXECUTE, writeback class (opcode low nibble in {1,2,3,4,5,6,7,8,A,B,C,D}) -> go to WRITEBACK.
REQ-023 EXECUTE, no-writeback class (low nibble in {9,E,F}, or instruction == 8'h00) -> go to FETCH and increment retired.
REQ-024 WRITEBACK -> OUTPUT on the next edge.
REQ-025 OUTPUT -> FETCH on the next edge; increment retired.
REQ-026 Latency, counted from the fetch-accept edge to the return to FETCH:
- No-writeback instructions: 3 cycles.
- Writeback instructions: 5 cycles.
REQ-027 FETCH can accept back to back; no idle cycle is inserted.
REQ-028 HALT is absorbing until rst:
- mem_req = 0.
- instruction holds.
- retired holds.
- step and run have no effect.
REQ-029 instruction changes only on fetch accept.
REQ-030 retired wraps from 8'hFF to 8'h00 without a flag.
REQ-031 ena=0 freezes the state, instruction, retired, halted and step_pending registers and the step edge detector.
REQ-032 Simultaneous events: rst dominates ena, step and mem_valid.
REQ-033 Simultaneous events: a step edge in the same cycle as a fetch accept does not leave step_pending set.

Reset
REQ-034 On rst=1 at a clock edge, regardless of ena, the block enters this state:
- state = FETCH
- instruction = 8'h00
- retired = 8'h00
- halted = 0
- step_pending = 0
- step edge history = 0
REQ-035 rst asserted mid-instruction (any state, including HALT) abandons the instruction without incrementing retired.

Structure
REQ-036 Shared package cpu_pkg holds:
- the 3-bit state encodings
- opcode nibble constants (LOAD=4'hA, JUMP=4'h9, BEZ=4'hE, BNEZ=4'hF)
- the NOP value 8'h00
REQ-037 One combinational sub-module, instr_class, maps instruction[3:0] to a writeback/no-writeback class; it is shared with the control LUT.
REQ-038 The sequencer itself is a single registered FSM with registered outputs for instruction, retired and halted.

Verification
REQ-039 Writeback path: run=1, mem_valid=1, instr_in=8'hBA -> state sequence 000,001,010,011,100,000; retired 0->1.
REQ-040 Branch path: run=1, instr_in=8'h1E, legal ctrl_in -> state sequence 000,001,010,000; retired increments on the EXECUTE->FETCH edge.
REQ-041 Illegal instruction: instr_in=8'hC5, ctrl_in=16'h0000 in DECODE -> state 111 and halted=1; mem_req stays 0 for 20 further cycles with mem_valid=1.
REQ-042 Single step: run=0, one step pulse, mem_valid=1 -> exactly one instr_in=8'h09 executes; a second fetch waits in FETCH with mem_req=0 until the next step edge.
REQ-043 Wrap and reset: 256 NOPs (8'h00) -> retired reads 8'h00.
REQ-044 Reset and freeze: rst during WRITEBACK -> next cycle state=000 and retired unchanged-to-zero; ena=0 for 5 cycles mid-EXECUTE -> no state change.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the control sequencer, its instruction classifier and the control LUT.
package cpu_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned OP_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 3'b000,
    ST_DECODE    = 3'b001,
    ST_EXECUTE   = 3'b010,
    ST_WRITEBACK = 3'b011,
    ST_OUTPUT    = 3'b100,
    ST_HALT      = 3'b111
  } state_e;

  localparam logic [OP_W-1:0]    OP_LOAD = 4'hA;
  localparam logic [OP_W-1:0]    OP_JUMP = 4'h9;
  localparam logic [OP_W-1:0]    OP_BEZ  = 4'hE;
  localparam logic [OP_W-1:0]    OP_BNEZ = 4'hF;
  localparam logic [INSTR_W-1:0] NOP     = 8'h00;

endpackage

// File: rtl/instr_class.sv
// Opcode classifier: flags opcodes whose result must pass through WRITEBACK/OUTPUT.
module instr_class
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output logic            writeback_c_o
);

  // Jumps, branches and the zero nibble (NOP) retire straight from EXECUTE.
  always_comb begin
    writeback_c_o = 1'b1;
    case (opcode_i)
      OP_JUMP, OP_BEZ, OP_BNEZ, 4'h0: writeback_c_o = 1'b0;
      OP_LOAD:                        writeback_c_o = 1'b1;
      default:                        writeback_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer FSM: fetch gating (run/single-step), decode halt, execute class
// routing and retired-instruction counting.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               run,
  input  logic               step,
  input  logic               mem_valid,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  output logic [STATE_W-1:0] state,
  output logic [INSTR_W-1:0] instruction,
  output logic               mem_req,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               halted_q, halted_d;
  logic               step_pend_q, step_pend_d;
  logic               step_prev_q, step_prev_d;

  logic writeback_c;
  logic fetch_go_c;
  logic accept_c;
  logic step_rise_c;

  instr_class u_instr_class (
    .opcode_i      (instr_q[OP_W-1:0]),
    .writeback_c_o (writeback_c)
  );

  assign step_rise_c = step && !step_prev_q;
  assign fetch_go_c  = (state_q == ST_FETCH) && (run || step_pend_q) && !halted_q;
  assign accept_c    = fetch_go_c && mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      instr_q     <= NOP;
      retired_q   <= '0;
      halted_q    <= 1'b0;
      step_pend_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      halted_q    <= halted_d;
      step_pend_q <= step_pend_d;
      step_prev_q <= step_prev_d;
    end
  end

  // A step edge coinciding with a fetch accept is consumed by that fetch.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    halted_d    = halted_q;
    step_prev_d = step;
    step_pend_d = step_pend_q || step_rise_c;

    case (state_q)
      ST_FETCH: begin
        if (accept_c) begin
          instr_d     = instr_in;
          state_d     = ST_DECODE;
          step_pend_d = 1'b0;
        end
      end
      ST_DECODE: begin
        if ((ctrl_in == '0) && (instr_q != NOP)) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (writeback_c && (instr_q != NOP)) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d   = ST_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      ST_WRITEBACK: state_d = ST_OUTPUT;
      ST_OUTPUT: begin
        state_d   = ST_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  assign state       = state_q;
  assign instruction = instr_q;
  assign retired     = retired_q;
  assign halted      = halted_q;
  assign mem_req     = fetch_go_c;

endmodule
